// File: rtl/atm_txn_controller_pkg.sv
// Shared types for the ATM transaction controller: FSM states and error codes.
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PIN,
        WAIT_AMT,
        CHECK,
        DISPENSE,
        EJECT,
        RETAIN,
        WAIT_REMOVE
    } atm_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_TIMEOUT,
        ERR_AMOUNT,
        ERR_LOCKOUT
    } atm_err_t;

    // Only the two customer-input states run the inactivity timer.
    function automatic logic is_wait_state(input atm_state_t s);
        return (s == WAIT_PIN) || (s == WAIT_AMT);
    endfunction

endpackage

// File: rtl/atm_txn_controller_timer.sv
// Inactivity down-counter: reload to TIMEOUT-1, count while enabled, flag expiry at zero.
module atm_timeout_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  RELOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: async reset sits in the sensitivity list; every flop clears the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count value present on entry is the first idle cycle, so TIMEOUT idle cycles elapse.
    assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/atm_txn_controller.sv
// ATM transaction FSM: PIN with retry lockout, amount check, note-by-note dispense, card handling.
module atm_txn_controller
    import atm_pkg::*;
#(
    parameter int AMT_W     = 8,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_NOTES = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_inserted,
    input  logic             pin_valid,
    input  logic             pin_correct,
    input  logic             amt_valid,
    input  logic [AMT_W-1:0] amt_req,
    input  logic [AMT_W-1:0] balance,
    output logic             note_req,
    input  logic             note_ack,
    output logic             card_eject,
    output logic             card_retain,
    output logic             txn_done,
    output logic [AMT_W-1:0] debit_amt,
    output logic [1:0]       err_code
);

    localparam int               TRY_W       = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST    = TRY_W'(MAX_TRIES - 1);
    localparam logic [AMT_W-1:0] MAX_NOTES_W = AMT_W'(MAX_NOTES);

    atm_state_t       state_q, state_d;
    atm_err_t         err_q, err_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [AMT_W-1:0] bal_q, bal_d;
    logic [AMT_W-1:0] debit_q, debit_d;
    logic             note_req_q, note_req_d;
    logic             card_eject_q, card_eject_d;
    logic             card_retain_q, card_retain_d;
    logic             txn_done_q, txn_done_d;

    logic timer_reload;
    logic timer_expired;
    logic wrong_pin_retry;
    logic amount_bad;

    atm_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .reload  (timer_reload),
        .enable  (is_wait_state(state_q)),
        .expired (timer_expired)
    );

    assign amount_bad = (amt_q == '0) || (amt_q > MAX_NOTES_W) || (amt_q > bal_q);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        err_d           = err_q;
        tries_d         = tries_q;
        remaining_d     = remaining_q;
        amt_d           = amt_q;
        bal_d           = bal_q;
        debit_d         = debit_q;
        txn_done_d      = 1'b0;
        wrong_pin_retry = 1'b0;

        case (state_q)
            IDLE: begin
                if (card_inserted) begin
                    state_d = WAIT_PIN;
                    tries_d = '0;
                end
            end
            WAIT_PIN: begin
                if (!card_inserted) begin
                    state_d = IDLE;
                end else if (pin_valid) begin
                    if (pin_correct) begin
                        state_d = WAIT_AMT;
                    end else if (tries_q == TRY_LAST) begin
                        tries_d = tries_q + 1'b1;
                        state_d = RETAIN;
                        err_d   = ERR_LOCKOUT;
                    end else begin
                        tries_d         = tries_q + 1'b1;
                        wrong_pin_retry = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d = EJECT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            WAIT_AMT: begin
                if (!card_inserted) begin
                    state_d = IDLE;
                end else if (amt_valid) begin
                    amt_d   = amt_req;
                    bal_d   = balance;
                    state_d = CHECK;
                end else if (timer_expired) begin
                    state_d = EJECT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (!card_inserted) begin
                    state_d = IDLE;
                end else if (amount_bad) begin
                    state_d = EJECT;
                    err_d   = ERR_AMOUNT;
                end else begin
                    remaining_d = amt_q;
                    state_d     = DISPENSE;
                end
            end
            DISPENSE: begin
                // Card removal is deliberately not looked at: notes already requested must complete.
                if (note_ack) begin
                    if (remaining_q == AMT_W'(1)) begin
                        remaining_d = '0;
                        debit_d     = amt_q;
                        txn_done_d  = 1'b1;
                        err_d       = ERR_NONE;
                        state_d     = EJECT;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            EJECT, RETAIN: begin
                state_d = WAIT_REMOVE;
            end
            WAIT_REMOVE: begin
                if (!card_inserted) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        timer_reload  = wrong_pin_retry ||
                        (is_wait_state(state_d) && (state_d != state_q));
        note_req_d    = (state_d == DISPENSE);
        card_eject_d  = (state_d == EJECT);
        card_retain_d = (state_d == RETAIN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            err_q         <= ERR_NONE;
            tries_q       <= '0;
            remaining_q   <= '0;
            amt_q         <= '0;
            bal_q         <= '0;
            debit_q       <= '0;
            note_req_q    <= 1'b0;
            card_eject_q  <= 1'b0;
            card_retain_q <= 1'b0;
            txn_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            tries_q       <= tries_d;
            remaining_q   <= remaining_d;
            amt_q         <= amt_d;
            bal_q         <= bal_d;
            debit_q       <= debit_d;
            note_req_q    <= note_req_d;
            card_eject_q  <= card_eject_d;
            card_retain_q <= card_retain_d;
            txn_done_q    <= txn_done_d;
        end
    end

    assign note_req    = note_req_q;
    assign card_eject  = card_eject_q;
    assign card_retain = card_retain_q;
    assign txn_done    = txn_done_q;
    assign debit_amt   = debit_q;
    assign err_code    = err_q;

    a_note_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (note_req_q && !note_ack) |=> note_req_q);

    a_eject_retain_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(card_eject_q && card_retain_q));

    a_debit_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        txn_done_q |-> (debit_q <= MAX_NOTES_W));

endmodule

// File: tb/tb_atm_txn_controller.sv
// Directed self-checking bench for atm_txn_controller; expected values are hand-derived constants.
module tb_atm_txn_controller;
    import atm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       card_inserted = 1'b0;
    logic       pin_valid = 1'b0;
    logic       pin_correct = 1'b0;
    logic       amt_valid = 1'b0;
    logic [7:0] amt_req = '0;
    logic [7:0] balance = '0;
    logic       note_req;
    logic       note_ack = 1'b0;
    logic       card_eject;
    logic       card_retain;
    logic       txn_done;
    logic [7:0] debit_amt;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;

    int done_cnt = 0;
    int req_cyc  = 0;
    int snap_done;
    int snap_req;

    atm_txn_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .card_inserted (card_inserted),
        .pin_valid     (pin_valid),
        .pin_correct   (pin_correct),
        .amt_valid     (amt_valid),
        .amt_req       (amt_req),
        .balance       (balance),
        .note_req      (note_req),
        .note_ack      (note_ack),
        .card_eject    (card_eject),
        .card_retain   (card_retain),
        .txn_done      (txn_done),
        .debit_amt     (debit_amt),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    // Event monitors sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (txn_done) done_cnt++;
        if (note_req) req_cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_pin(input logic correct);
        pin_valid   = 1'b1;
        pin_correct = correct;
        tick();
        pin_valid   = 1'b0;
        pin_correct = 1'b0;
    endtask

    // Card in, correct PIN, amount entered; returns with the DUT in CHECK.
    task automatic enter_amt(input logic [7:0] amt, input logic [7:0] bal);
        card_inserted = 1'b1;
        tick();
        pulse_pin(1'b1);
        amt_valid = 1'b1;
        amt_req   = amt;
        balance   = bal;
        tick();
        amt_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        note_ack = 1'b1;
        tick();
        note_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_note_req", 32'(note_req), 0);
        chk("rst_debit", 32'(debit_amt), 0);
        chk("rst_err", 32'(err_code), 0);
        rst_n = 1'b1;
        tick();

        // 1) Normal withdrawal of 5 notes, ack every second cycle
        snap_done = done_cnt;
        card_inserted = 1'b1;
        tick();
        chk("t1_wait_pin", 32'(dut.state_q), 32'(WAIT_PIN));
        pulse_pin(1'b1);
        chk("t1_wait_amt", 32'(dut.state_q), 32'(WAIT_AMT));
        amt_valid = 1'b1;
        amt_req   = 8'd5;
        balance   = 8'd100;
        tick();
        amt_valid = 1'b0;
        chk("t1_req_in_check", 32'(note_req), 0);
        tick();
        chk("t1_req_up", 32'(note_req), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            pulse_ack();
            if (i < 4) begin
                chk("t1_req_held", 32'(note_req), 1);
                chk("t1_no_done_yet", 32'(txn_done), 0);
            end
        end
        chk("t1_done", 32'(txn_done), 1);
        chk("t1_eject", 32'(card_eject), 1);
        chk("t1_debit", 32'(debit_amt), 5);
        chk("t1_err", 32'(err_code), 0);
        chk("t1_req_drop", 32'(note_req), 0);
        tick();
        chk("t1_done_pulse", 32'(txn_done), 0);
        chk("t1_eject_pulse", 32'(card_eject), 0);
        chk("t1_debit_held", 32'(debit_amt), 5);
        chk("t1_done_once", 32'(done_cnt - snap_done), 1);
        card_inserted = 1'b0;
        tick();
        chk("t1_idle", 32'(dut.state_q), 32'(IDLE));

        // 2) Three wrong PINs -> retain with lockout
        snap_req = req_cyc;
        card_inserted = 1'b1;
        tick();
        pulse_pin(1'b0);
        chk("t2_try1", 32'(card_retain), 0);
        pulse_pin(1'b0);
        chk("t2_try2", 32'(card_retain), 0);
        pulse_pin(1'b0);
        chk("t2_retain", 32'(card_retain), 1);
        chk("t2_err", 32'(err_code), 3);
        chk("t2_no_eject", 32'(card_eject), 0);
        tick();
        chk("t2_retain_pulse", 32'(card_retain), 0);
        chk("t2_no_notes", 32'(req_cyc - snap_req), 0);
        card_inserted = 1'b0;
        tick();

        // 3) Bad amounts, then the MAX_NOTES == balance boundary that must pass
        snap_req = req_cyc;
        enter_amt(8'd50, 8'd100);
        tick();
        chk("t3a_eject", 32'(card_eject), 1);
        chk("t3a_err", 32'(err_code), 2);
        tick();
        card_inserted = 1'b0;
        tick();
        enter_amt(8'd30, 8'd20);
        tick();
        chk("t3b_eject", 32'(card_eject), 1);
        chk("t3b_err", 32'(err_code), 2);
        chk("t3_no_notes", 32'(req_cyc - snap_req), 0);
        tick();
        card_inserted = 1'b0;
        tick();
        enter_amt(8'd40, 8'd40);
        tick();
        chk("t3c_req_up", 32'(note_req), 1);
        note_ack = 1'b1;
        tick(39);
        chk("t3c_req_39", 32'(note_req), 1);
        chk("t3c_no_done_39", 32'(txn_done), 0);
        tick();
        note_ack = 1'b0;
        chk("t3c_done", 32'(txn_done), 1);
        chk("t3c_debit", 32'(debit_amt), 40);
        chk("t3c_err", 32'(err_code), 0);
        tick();
        card_inserted = 1'b0;
        tick();

        // 4) Inactivity timeout in WAIT_PIN, then PIN arriving in the expiry cycle
        card_inserted = 1'b1;
        tick();
        tick(1023);
        chk("t4_no_eject_early", 32'(card_eject), 0);
        tick();
        chk("t4_eject", 32'(card_eject), 1);
        chk("t4_err", 32'(err_code), 1);
        tick();
        card_inserted = 1'b0;
        tick();
        card_inserted = 1'b1;
        tick();
        tick(1023);
        pulse_pin(1'b1);
        chk("t4v_no_eject", 32'(card_eject), 0);
        chk("t4v_wait_amt", 32'(dut.state_q), 32'(WAIT_AMT));
        tick();
        chk("t4v_no_eject_late", 32'(card_eject), 0);

        // 5a) Card pulled in WAIT_AMT -> IDLE silently, err_code untouched
        card_inserted = 1'b0;
        tick();
        chk("t5a_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t5a_no_eject", 32'(card_eject), 0);
        chk("t5a_no_retain", 32'(card_retain), 0);
        chk("t5a_err_kept", 32'(err_code), 1);

        // 5b) Card pulled in DISPENSE with 3 notes left; amt == balance
        enter_amt(8'd4, 8'd4);
        tick();
        pulse_ack();
        card_inserted = 1'b0;
        tick(2);
        chk("t5b_still_disp", 32'(dut.state_q), 32'(DISPENSE));
        chk("t5b_req_held", 32'(note_req), 1);
        pulse_ack();
        pulse_ack();
        pulse_ack();
        chk("t5b_done", 32'(txn_done), 1);
        chk("t5b_debit", 32'(debit_amt), 4);
        chk("t5b_eject", 32'(card_eject), 1);
        tick(2);
        chk("t5b_idle", 32'(dut.state_q), 32'(IDLE));

        // 6) Reset mid-dispense aborts at once
        enter_amt(8'd5, 8'd10);
        tick();
        chk("t6_req_up", 32'(note_req), 1);
        pulse_ack();
        snap_done = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(note_req), 0);
        chk("t6_state_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t6_no_done", 32'(txn_done), 0);
        note_ack = 1'b1;
        tick(3);
        note_ack = 1'b0;
        rst_n = 1'b1;
        tick(2);
        chk("t6_req_after", 32'(note_req), 0);
        chk("t6_debit_cleared", 32'(debit_amt), 0);
        chk("t6_done_never", 32'(done_cnt - snap_done), 0);
        card_inserted = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
